wand_hit_detector: RTL and testbench

WAND_HIT_DETECTOR -- requirements
Module: wand_hit_detector

---
 rtl/wand_hit_detector.sv | 157 +++++++++++++++
 tb/tb_wand_hit_detector.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wand_hit_detector.sv
// IR wand hit detector: per-sensor sync, whole-vector debounce, edge pick and hit/cooldown FSM.
// Optional hit counter is built only when WAND_HIT_COUNT_EN is defined.
module wand_hit_detector #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int COOLDOWN_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [15:0] ir_in,
  input  logic        enable,
  input  logic        count_clr,
  output logic        hit,
  output logic [3:0]  hit_index,
  output logic        busy,
  output logic [15:0] hit_count
);

  localparam int NUM_LANES = 16;
  localparam int DB_W      = 8;
  localparam int CD_W      = 20;

  typedef enum logic [1:0] {S_IDLE, S_HIT, S_COOLDOWN} state_t;

  logic [NUM_LANES-1:0] w_sync;
  logic [NUM_LANES-1:0] r_sync_prev;
  logic [NUM_LANES-1:0] r_deb;
  logic [NUM_LANES-1:0] r_deb_prev;
  logic [NUM_LANES-1:0] w_rise;
  logic [DB_W-1:0]      r_db_cnt;
  logic                 w_stable;
  logic                 w_load;
  logic                 w_any;
  logic [3:0]           w_idx;

  state_t               r_state, w_state_nxt;
  logic [CD_W-1:0]      r_cd_cnt, w_cd_nxt;
  logic                 w_capture;
  logic [3:0]           r_hit_index;

  // Per-lane two-flop synchroniser and rising-edge detect on the debounced bit.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic r_meta, r_sync;
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_meta <= 1'b0;
        r_sync <= 1'b0;
      end else begin
        r_meta <= ir_in[g];
        r_sync <= r_meta;
      end
    end
    assign w_sync[g] = r_sync;
    assign w_rise[g] = r_deb[g] & ~r_deb_prev[g];
  end

  assign w_stable = (w_sync == r_sync_prev);
  // Requiring stability on the load cycle stops a one-cycle change from slipping in.
  assign w_load   = w_stable && (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_sync_prev <= '0;
      r_db_cnt    <= '0;
      r_deb       <= '0;
      r_deb_prev  <= '0;
    end else begin
      r_sync_prev <= w_sync;
      if (!w_stable)
        r_db_cnt <= '0;
      else if (r_db_cnt != DB_W'(DEBOUNCE_CYCLES))
        r_db_cnt <= r_db_cnt + DB_W'(1);
      if (w_load)
        r_deb <= w_sync;
      r_deb_prev <= r_deb;
    end
  end

  // Lowest-numbered rising edge wins; the rest are dropped.
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      if (w_rise[i]) begin
        w_any = 1'b1;
        w_idx = 4'(i);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_cd_cnt    <= '0;
      r_hit_index <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cd_cnt <= w_cd_nxt;
      if (w_capture)
        r_hit_index <= w_idx;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cd_nxt    = r_cd_cnt;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_HIT;
          w_capture   = 1'b1;
        end
      end
      S_HIT: begin
        w_state_nxt = S_COOLDOWN;
        w_cd_nxt    = '0;
      end
      S_COOLDOWN: begin
        if (r_cd_cnt == CD_W'(COOLDOWN_CYCLES - 1)) begin
          w_state_nxt = S_IDLE;
          w_cd_nxt    = '0;
        end else begin
          w_cd_nxt = r_cd_cnt + CD_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Game inactive: drop back to idle; a pulse already in flight has been seen.
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cd_nxt    = '0;
      w_capture   = 1'b0;
    end
  end

  assign hit       = (r_state == S_HIT);
  assign busy      = (r_state != S_IDLE);
  assign hit_index = r_hit_index;

`ifdef WAND_HIT_COUNT_EN
  logic [15:0] r_hit_count;
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      r_hit_count <= '0;
    else if (count_clr)
      r_hit_count <= '0;
    else if (hit && (r_hit_count != 16'hFFFF))
      r_hit_count <= r_hit_count + 16'd1;
  end
  assign hit_count = r_hit_count;
`else
  logic w_unused_count_clr;
  assign w_unused_count_clr = count_clr;
  assign hit_count          = '0;
`endif

endmodule

// File: tb/tb_wand_hit_detector.sv
// Directed bench for wand_hit_detector with DEBOUNCE_CYCLES=4, COOLDOWN_CYCLES=10.
module tb_wand_hit_detector;
  localparam int DB = 4;
  localparam int CD = 10;
`ifdef WAND_HIT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clock     = 1'b0;
  logic        resetn    = 1'b0;
  logic        enable    = 1'b0;
  logic        count_clr = 1'b0;
  logic [15:0] ir_in     = '0;
  logic        hit, busy;
  logic [3:0]  hit_index;
  logic [15:0] hit_count;

  int n_chk  = 0;
  int n_pass = 0;
  int nh, ncyc;
  logic [3:0] idx;

  always #5 clock = ~clock;

  wand_hit_detector #(.DEBOUNCE_CYCLES(DB), .COOLDOWN_CYCLES(CD)) dut (
    .clock(clock), .resetn(resetn), .ir_in(ir_in), .enable(enable),
    .count_clr(count_clr), .hit(hit), .hit_index(hit_index),
    .busy(busy), .hit_count(hit_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
    return CNT_EN ? 32'(n) : 32'd0;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic run_hits(input int n, output int hits, output logic [3:0] last);
    hits = 0;
    last = '0;
    repeat (n) begin
      @(negedge clock);
      if (hit) begin
        hits++;
        last = hit_index;
      end
    end
  endtask

  task automatic wait_hit(input int max, output int n, output logic [3:0] last);
    n    = -1;
    last = '0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clock);
      if (hit) begin
        n    = i;
        last = hit_index;
        break;
      end
    end
  endtask

  initial begin
    // reset state
    cyc(2);
    chk("rst_hit", hit, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_idx", hit_index, 4'd0);
    chk("rst_cnt", hit_count, 16'd0);

    // sensor high at reset release: hit in cycle 7, busy 7..17
    ir_in  = 16'h0020;
    enable = 1'b1;
    cyc(1);
    resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk($sformatf("r030_hit_c%0d", c), hit, (c == 7));
      chk($sformatf("r030_busy_c%0d", c), busy, (c >= 7 && c <= 17));
      if (c == 7) chk("r030_idx", hit_index, 4'd5);
    end
    chk("r030_cnt", hit_count, cnt_exp(1));
    run_hits(30, nh, idx);
    chk("held_no_rehit", nh, 0);

    // clear counter, then a 3-cycle glitch must be ignored
    ir_in = '0;
    cyc(20);
    count_clr = 1'b1;
    cyc(1);
    count_clr = 1'b0;
    chk("clr_cnt", hit_count, 16'd0);
    ir_in = 16'h0004;
    cyc(3);
    ir_in = '0;
    run_hits(30, nh, idx);
    chk("glitch_hits", nh, 0);
    chk("glitch_cnt", hit_count, 16'd0);

    // simultaneous edges: lowest index only
    ir_in = 16'h8104;
    wait_hit(20, ncyc, idx);
    chk("r032_lat", ncyc, DB + 4);
    chk("r032_idx", idx, 4'd2);
    run_hits(40, nh, idx);
    chk("r032_held", nh, 0);
    chk("r032_cnt", hit_count, cnt_exp(1));
    ir_in = '0;
    cyc(20);

    // edge during cooldown is dropped; later edge accepted
    count_clr = 1'b1;
    cyc(1);
    count_clr = 1'b0;
    ir_in = 16'h0001;
    wait_hit(20, ncyc, idx);
    chk("r033_lat", ncyc, DB + 4);
    chk("r033_idx0", idx, 4'd0);
    cyc(1);
    ir_in = 16'h0201;
    run_hits(30, nh, idx);
    chk("r033_cd_drop", nh, 0);
    ir_in = 16'h0001;
    cyc(20);
    ir_in = 16'h0201;
    wait_hit(20, ncyc, idx);
    chk("r033_idx9", idx, 4'd9);
    cyc(1);
    chk("r033_cnt", hit_count, cnt_exp(2));

    // enable low during cooldown, and edges while disabled
    ir_in = '0;
    cyc(20);
    ir_in = 16'h0008;
    wait_hit(20, ncyc, idx);
    chk("r034_idx", idx, 4'd3);
    cyc(2);
    chk("r034_busy_cd", busy, 1'b1);
    enable = 1'b0;
    cyc(1);
    chk("r034_busy_off", busy, 1'b0);
    ir_in = 16'h0018;
    run_hits(30, nh, idx);
    chk("r034_dis_hits", nh, 0);
    enable = 1'b1;
    run_hits(30, nh, idx);
    chk("r034_reen_hits", nh, 0);

    // reset mid-cooldown
    ir_in = '0;
    cyc(20);
    ir_in = 16'h0040;
    wait_hit(20, ncyc, idx);
    chk("r027_idx", idx, 4'd6);
    cyc(2);
    resetn = 1'b0;
    #1;
    chk("r027_busy", busy, 1'b0);
    chk("r027_idx0", hit_index, 4'd0);
    chk("r027_cnt", hit_count, 16'd0);
    ir_in = '0;
    cyc(2);
    resetn = 1'b1;
    run_hits(30, nh, idx);
    chk("r027_nohit", nh, 0);

`ifdef WAND_HIT_COUNT_EN
    // saturation and clear-wins-over-hit
    force dut.r_hit_count = 16'hFFFE;
    cyc(1);
    release dut.r_hit_count;
    cyc(1);
    chk("sat_pre", hit_count, 16'hFFFE);
    ir_in = 16'h0002;
    wait_hit(20, ncyc, idx);
    cyc(1);
    chk("sat_ffff", hit_count, 16'hFFFF);
    ir_in = '0;
    cyc(20);
    ir_in = 16'h0002;
    wait_hit(20, ncyc, idx);
    cyc(1);
    chk("sat_hold", hit_count, 16'hFFFF);
    ir_in = '0;
    cyc(20);
    ir_in = 16'h0002;
    wait_hit(20, ncyc, idx);
    chk("clr_hit_seen", ncyc, DB + 4);
    count_clr = 1'b1;
    cyc(1);
    count_clr = 1'b0;
    chk("clr_with_hit", hit_count, 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
